// File: rtl/accu_avg_buf.sv
// accu_avg_buf: turns 10-bit group sums into rounded 8-bit averages.
// The averages are held in a small FIFO and handed to the consumer on a
// valid/ready handshake. Sums that arrive while the FIFO is full, with no
// pop in the same cycle, are discarded and counted, so the upstream
// accumulator never sees back-pressure.
module accu_avg_buf #(
  parameter int DEPTH  = 4,   // FIFO entries, power of two in 2..16
  parameter int DROP_W = 8    // width of the saturating drop counter
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               data_in,
  input  logic                     valid_in,
  input  logic                     ready_in,
  output logic                     valid_out,
  output logic [7:0]               data_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]     LEVEL_FULL = LW'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX   = '1;

  // Rounding and conversion path
  logic [10:0] rnd_sum;
  logic [10:0] rnd_shift;
  logic [7:0]  avg;

  // FIFO state
  logic [7:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic [LW-1:0]     level_next;
  logic [DROP_W-1:0] drop_cnt_reg;

  // Handshake decode
  logic push;
  logic pop;
  logic drop;

  // Round to nearest (add half of the divisor, then divide by 4). Legal sums
  // stay within 255; the out-of-range codes 1022/1023 overflow the 8-bit
  // result and are clamped to 255.
  always_comb begin
    rnd_sum   = {1'b0, data_in} + 11'd2;
    rnd_shift = rnd_sum >> 2;
    avg       = (rnd_shift > 11'd255) ? 8'hFF : rnd_shift[7:0];
  end

  // Status flags come only from the registered occupancy, so there is no
  // combinational path from valid_in/ready_in to full/empty/level.
  assign full      = (level_reg == LEVEL_FULL);
  assign empty     = (level_reg == '0);
  assign level     = level_reg;
  assign valid_out = !empty;
  assign data_out  = valid_out ? mem[rd_ptr_reg] : 8'h00;
  assign drop_cnt  = drop_cnt_reg;

  // A pop frees the head slot in the same cycle, so a full FIFO that is
  // being read still accepts the incoming sum instead of dropping it.
  assign pop  = valid_out && ready_in;
  assign push = valid_in && (!full || pop);
  assign drop = valid_in && full && !pop;

  // Occupancy update: simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  // Storage write; the array carries no reset since the pointers and level
  // already mark every entry as invalid after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= avg;
    end
  end

  // Pointers wrap naturally modulo DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      level_reg <= level_next;
    end
  end

  // Count discarded sums, holding at the maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != DROP_MAX)) begin
      drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
    end
  end

endmodule
